pixel_fetch_pipe: RTL and testbench
===================================

// Module: pixel_fetch_pipe
// PURPOSE
//  Parametrised, pipelined pixel fetcher for the frame-buffer read path. Accepts (line, offset)
//  requests over a valid/ready handshake and issues reads to an external multi-channel pixel RAM
//  with fixed read latency. Returns packed pixels in request order through an output FIFO with
//  backpressure. Out-of-range requests are flagged, zero-filled and counted.
// PARAMETERS
//  H_RES       128  visible pixels per line
//  V_RES       96   visible lines
//  LINE_W      7    request line field width
//  OFF_W       7    request offset field width
//  CHANNELS    3    colour channels per pixel (MSB channel = red)
//  CH_BITS     1    bits per channel
//  MEM_LAT     2    cycles from mem_en to valid mem_rdata (>=1)
//  FIFO_DEPTH  4    output FIFO entries; must be >= MEM_LAT+2 for 1 pixel/cycle
//  ADDR_W      14   mem_addr width; must hold V_RES*H_RES-1
// PORTS
//  clk           in   1                  rising-edge clock
//  reset         in   1                  asynchronous, active-low reset (0 = in reset)
//  req_valid     in   1                  request present
//  req_ready     out  1                  request accepted when req_valid & req_ready
//  req_line      in   LINE_W             requested line
//  req_offset    in   OFF_W              requested pixel offset within line
//  mem_en        out  1                  RAM read strobe
//  mem_addr      out  ADDR_W             RAM read address
//  mem_rdata     in   CHANNELS*CH_BITS   RAM data, valid MEM_LAT cycles after mem_en
//  pix_valid     out  1                  FIFO head valid
//  pix_ready     in   1                  consumer pops head when pix_valid & pix_ready
//  pix_data      out  CHANNELS*CH_BITS   packed pixel {ch[CHANNELS-1] .. ch[0]}
//  pix_in_range  out  1                  head request was inside V_RES x H_RES
//  busy          out  1                  any request in flight or FIFO non-empty
//  oor_count     out  16                 out-of-range requests since reset, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): in-flight pipe and FIFO flushed; pix_valid=0, mem_en=0,
//    busy=0, oor_count=0, pix_data=0, pix_in_range=0, req_ready=0 while reset is low.
//  - in_range = (req_line < V_RES) && (req_offset < H_RES).
//  - mem_addr = req_line*H_RES + req_offset, zero-extended to ADDR_W; combinational in accept cycle.
//  - mem_en = accept & in_range; out-of-range accepts never strobe the RAM (mem_addr don't-care).
//  - Pipe: MEM_LAT-stage shift register carrying {valid, in_range}; every accept enters it.
//  - At stage MEM_LAT exit, push {in_range ? mem_rdata : 0, in_range} into FIFO; order preserved.
//  - Latency: accept at cycle T -> pix_valid high at T+MEM_LAT+1 (FIFO empty, first-word fall-through).
//  - Credit: req_ready = (inflight + fifo_count) < FIFO_DEPTH, from registered counts only; never
//    depends on pix_ready or req_valid. Guarantees FIFO never overflows; no push is ever dropped.
//  - Simultaneous push and pop: count unchanged, head advances; pop on empty impossible (pix_valid=0).
//  - pix_data / pix_in_range stable while pix_valid & !pix_ready.
//  - oor_count += 1 on each out-of-range accept; holds at 16'hFFFF.
//  - busy = (inflight != 0) | (fifo_count != 0).
//  - Reset mid-operation: all pending results discarded; no stale pixel after release.
// TESTING
//  1. Reset low, req_valid=1 -> req_ready=0, mem_en=0, pix_valid=0, oor_count=0; release -> req_ready=1.
//  2. Single req line=5, offset=10, RAM model rdata=addr[2:0] -> mem_addr=650, pix_data=3'b010,
//     pix_in_range=1, pix_valid rises exactly 3 cycles after accept (MEM_LAT=2).
//  3. 200 back-to-back in-range reqs, pix_ready=1 -> req_ready never drops, 1 pixel/cycle, order matches.
//  4. pix_ready=0, stream reqs -> exactly 4 accepts then req_ready=0; pix_ready=1 -> all 4 delivered in order.
//  5. Reqs (0,0),(96,0),(0,128),(95,127) -> mem_en only for 1st/4th, pix_in_range 1,0,0,1,
//     pix_data 0 for OOR, oor_count=2; 70000 OOR reqs -> oor_count=16'hFFFF.
//  6. Reset pulsed with 2 in flight and 2 in FIFO -> pix_valid=0, busy=0 immediately; no pixel after release.

Source files
------------

// File: rtl/pixel_fetch_pipe.sv
// Pipelined frame-buffer pixel fetcher: accepts (line, offset) requests, reads a fixed-latency
// pixel RAM and returns zero-filled, range-flagged pixels in order through a credit-guarded FIFO.
`timescale 1ns/1ps

module pixel_fetch_pipe #(
  parameter int H_RES      = 128,
  parameter int V_RES      = 96,
  parameter int LINE_W     = 7,
  parameter int OFF_W      = 7,
  parameter int CHANNELS   = 3,
  parameter int CH_BITS    = 1,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [LINE_W-1:0]            req_line,
  input  logic [OFF_W-1:0]             req_offset,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [CHANNELS*CH_BITS-1:0]  mem_rdata,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [CHANNELS*CH_BITS-1:0]  pix_data,
  output logic                         pix_in_range,
  output logic                         busy,
  output logic [15:0]                  oor_count
);

  localparam int PIX_W = CHANNELS * CH_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + MEM_LAT + 1) + 1;
  localparam logic [LINE_W:0] V_LIM = (LINE_W + 1)'(V_RES);
  localparam logic [OFF_W:0]  H_LIM = (OFF_W + 1)'(H_RES);

  logic               accept;
  logic               in_range;
  logic               push;
  logic               pop;
  logic [PIX_W-1:0]   push_data;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [MEM_LAT-1:0] pipe_v;
  logic [MEM_LAT-1:0] pipe_r;
  logic [PIX_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PIX_W:0]     head;

  // Request side: range check and address are purely combinational in the accept cycle.
  assign in_range = ({1'b0, req_line} < V_LIM) && ({1'b0, req_offset} < H_LIM);
  assign mem_addr = ADDR_W'(req_line) * ADDR_W'(H_RES) + ADDR_W'(req_offset);

  // Credit counts every slot a result could eventually occupy, so a push never finds the FIFO full.
  assign req_ready = reset && ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;
  assign mem_en    = accept & in_range;

  assign push      = pipe_v[MEM_LAT-1];
  assign push_data = pipe_r[MEM_LAT-1] ? mem_rdata : '0;
  assign pix_valid = (fifo_count != '0);
  assign pop       = pix_valid & pix_ready;
  assign busy      = (inflight != '0) | (fifo_count != '0);

  assign head         = fifo_mem[rd_ptr];
  assign pix_data     = pix_valid ? head[PIX_W:1] : '0;
  assign pix_in_range = pix_valid & head[0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v     <= '0;
      pipe_r     <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      oor_count  <= '0;
    end else begin
      pipe_v[0] <= accept;
      pipe_r[0] <= in_range;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_r[i] <= pipe_r[i-1];
      end

      inflight   <= inflight + CNT_W'(accept) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

      if (accept && !in_range && oor_count != 16'hFFFF)
        oor_count <= oor_count + 16'd1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the reset count/pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {push_data, pipe_r[MEM_LAT-1]};
  end

endmodule

// File: tb/tb_pixel_fetch_pipe.sv
// Scoreboard bench for pixel_fetch_pipe: directed requests push expected pixels, a negedge
// monitor compares the FIFO head against the queue front whenever a pixel is presented.
`timescale 1ns/1ps

module tb_pixel_fetch_pipe;

  typedef struct packed {
    logic [2:0] data;
    logic       inr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_line;
  logic [7:0]  req_offset;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [2:0]  mem_rdata;
  logic        pix_valid;
  logic        pix_ready;
  logic [2:0]  pix_data;
  logic        pix_in_range;
  logic        busy;
  logic [15:0] oor_count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Offset is one bit wider than the default so column 128 is representable and reachable.
  pixel_fetch_pipe #(.OFF_W(8)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_line     (req_line),
    .req_offset   (req_offset),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_in_range (pix_in_range),
    .busy         (busy),
    .oor_count    (oor_count)
  );

  always #5 clk = ~clk;

  // Two-cycle RAM model returning addr[2:0]; idle cycles return 3'b111 so zero-fill is visible.
  logic [13:0] ra0, ra1;
  logic        rv0, rv1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv0 <= 1'b0; rv1 <= 1'b0; ra0 <= '0; ra1 <= '0;
    end else begin
      rv0 <= mem_en; ra0 <= mem_addr;
      rv1 <= rv0;    ra1 <= ra0;
    end
  end
  assign mem_rdata = rv1 ? ra1[2:0] : 3'b111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int l, input int o);
    exp_t e;
    e.inr  = (l < 96) && (o < 128);
    e.data = e.inr ? 3'((l * 128 + o) & 7) : 3'b000;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && pix_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pixel", {31'd0, pix_valid}, 32'd0);
      end else begin
        check("pix_data", {29'd0, pix_data}, {29'd0, sb[0].data});
        check("pix_in_range", {31'd0, pix_in_range}, {31'd0, sb[0].inr});
        if (pix_ready) void'(sb.pop_front());
      end
    end
  end

  // Holds the request until accepted; strict demands acceptance in the first cycle.
  task automatic send(input int l, input int o, input bit strict);
    exp_t e;
    req_valid  = 1'b1;
    req_line   = l[6:0];
    req_offset = o[7:0];
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (strict && w == 0) check("ready_hold", {31'd0, req_ready}, 32'd1);
      if (req_ready) begin
        e = model(l, o);
        check("mem_en", {31'd0, mem_en}, {31'd0, e.inr});
        if (e.inr) check("mem_addr", {18'd0, mem_addr}, 32'(l * 128 + o));
        sb.push_back(e);
        @(posedge clk); #1;
        return;
      end
    end
    check("req_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) return;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_line   = 7'd1;
    req_offset = 8'd1;
    pix_ready  = 1'b1;

    // Reset state with a request pending.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_oor_count", {16'd0, oor_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pix_data", {29'd0, pix_data}, 32'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Single request: address 650, data 3'b010, pix_valid exactly three cycles after accept.
    send(5, 10, 1'b1);
    req_valid = 1'b0;
    @(negedge clk); check("lat_t1", {31'd0, pix_valid}, 32'd0);
    @(negedge clk); check("lat_t2", {31'd0, pix_valid}, 32'd0);
    @(negedge clk); check("lat_t3", {31'd0, pix_valid}, 32'd1);
    drain(20);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 200 back-to-back in-range requests at full rate.
    for (int i = 0; i < 200; i++) send((i * 7) % 96, (i * 13) % 128, 1'b1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("stream_rate", 32'(sb.size()), 32'd0);
    drain(20);

    // Backpressure: exactly FIFO_DEPTH accepts, then delivery in order.
    pix_ready  = 1'b0;
    acc        = 0;
    req_valid  = 1'b1;
    req_line   = 7'd3;
    req_offset = 8'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(model(3, acc));
        acc++;
      end
      @(posedge clk); #1;
      req_offset = 8'(acc);
    end
    req_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd4);
    @(negedge clk);
    check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    pix_ready = 1'b1;
    drain(20);

    // Range boundaries, then saturation of the out-of-range counter.
    send(0, 0, 1'b0);
    send(96, 0, 1'b0);
    send(0, 128, 1'b0);
    send(95, 127, 1'b0);
    req_valid = 1'b0;
    drain(20);
    check("oor_count_2", {16'd0, oor_count}, 32'd2);
    for (int i = 0; i < 70000; i++) begin
      send(100, i % 256, 1'b0);
      if (i == 65531) check("oor_count_fffe", {16'd0, oor_count}, 32'h0000FFFE);
      if (i == 65532) check("oor_count_ffff", {16'd0, oor_count}, 32'h0000FFFF);
    end
    req_valid = 1'b0;
    drain(20);
    check("oor_count_sat", {16'd0, oor_count}, 32'h0000FFFF);

    // Reset mid-operation with two results in flight and two in the FIFO.
    pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(10, 20 + i, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_oor", {16'd0, oor_count}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    pix_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_pixel", {31'd0, pix_valid}, 32'd0);
    end
    check("post_flush_busy", {31'd0, busy}, 32'd0);

    // Normal operation resumes after the mid-flight reset.
    @(posedge clk); #1;
    send(1, 3, 1'b1);
    req_valid = 1'b0;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
